// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor working DIGIT bits per clock,
// least significant digit first, with the carry held in a register between
// digits. A start/busy/done handshake wraps each operation, and the result
// registers hold the last completed result until the next completion.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one digit is added per clock; NDIG cycles in total
// DONE  | one-cycle done pulse; start here begins the next op with no bubble

module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    // Operand sign bits are kept aside because opa/opb are shifted away.
    logic             msb_a;
    logic             msb_b;

    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] acc_ext;
    logic [WIDTH-1:0]       acc_next;
    logic                   unused_acc_lsb;

    // One digit of the ripple: current low digits plus the registered carry.
    always_comb begin
        dsum = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, cin};
    end

    // New digit enters the accumulator from the MSB side; the oldest
    // DIGIT bits fall off the bottom (they were already moved upward).
    assign acc_ext        = {dsum[DIGIT-1:0], acc};
    assign acc_next       = acc_ext[WIDTH+DIGIT-1:DIGIT];
    assign unused_acc_lsb = ^acc_ext[DIGIT-1:0];

    // Sequencer, operand shifters, carry chain and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            cin      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            msb_a    <= 1'b0;
            msb_b    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        cin   <= sub;
                        msb_a <= a[WIDTH-1];
                        msb_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cin <= dsum[DIGIT];
                    opa <= opa >> DIGIT;
                    opb <= opb >> DIGIT;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_DIG) begin
                        sum      <= acc_next;
                        carry    <= dsum[DIGIT];
                        overflow <= (msb_a == msb_b) && (acc_next[WIDTH-1] != msb_a);
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
